cheri_data_sram_responder: RTL and testbench
============================================

# cheri_data_sram_responder

Memory-side responder for the CHERIoT core data port (req/gnt/rvalid protocol, 33-bit tagged words). It accepts core load and store requests and drives a single-port tagged SRAM macro. Capability-tag clearing on ordinary stores is done here. Responses are returned in order after a fixed, parameterised latency, and the bench can inject grant backpressure. The block sits between the core wrapper's data interface and the data RAM.

## Interface
- `AddrBase`, default 32'h200f_0000: byte base address of the SRAM window.
- `AddrSize`, default 32'h0001_0000: window size in bytes; power of two.
- `SramAw`, default 14: SRAM word-address width; equals log2(AddrSize/4).
- `ReadLatency`, default 1: cycles from accept to `data_rvalid_o`; legal range 1..3.
- `MaxOutstanding`, default 2: maximum number of accepted requests not yet responded.
- `clk_i` in 1: clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `data_req_i` in 1: request valid.
- `data_gnt_o` out 1: request accepted this cycle.
- `data_we_i` in 1: 1 = store.
- `data_is_cap_i` in 1: capability access.
- `data_be_i` in 4: byte enables.
- `data_addr_i` in 32: byte address.
- `data_wdata_i` in 33: store data; bit 32 is the tag.
- `data_rvalid_o` out 1: response valid; asserted for loads and stores.
- `data_rdata_o` out 33: load data; bit 32 is the tag.
- `data_err_o` out 1: error response; qualified by `data_rvalid_o`.
- `stall_i` in 1: injected backpressure; forces `data_gnt_o` low.
- `sram_cs_o` out 1: SRAM select.
- `sram_we_o` out 1: SRAM write.
- `sram_addr_o` out SramAw: SRAM word address.
- `sram_wmask_o` out 33: per-bit write mask.
- `sram_wdata_o` out 33: SRAM write data.
- `sram_rdata_i` in 33: SRAM read data, valid one cycle after `sram_cs_o`.

## Operation
- **Grant:** `data_gnt_o = data_req_i & ~stall_i & (out_cnt - rsp_now < MaxOutstanding)`. `rsp_now` is the `data_rvalid_o` of the current cycle. An accept is `req & gnt`.
- **Decode:** `in_range = (addr - AddrBase) < AddrSize`. `cap_bad = data_is_cap_i & (addr[1:0] != 0 | be != 4'hF)`. `err = ~in_range | cap_bad`.
- **Error accepts:** no SRAM access; `sram_cs_o` stays 0.
- **Valid accepts:** `sram_cs_o = 1` in the accept cycle. `sram_addr_o = (addr - AddrBase) >> 2`. `sram_we_o = data_we_i`.
- **Store mask:** bits [31:0] of `sram_wmask_o` take each `be[i]` replicated 8x. Bit 32 of the mask is always 1 on stores.
- **Store tag:**
  - Capability store writes `data_wdata_i[32]`.
  - Non-capability store writes tag 0, even for partial byte enables.
- **Store data:** bits [31:0] of `sram_wdata_o` are `data_wdata_i[31:0]`.
- **Response pipeline:** an in-order shift pipeline of depth ReadLatency. Each entry is {valid, err, is_cap, we}. Load data from `sram_rdata_i` is captured at stage 1 and carried through the remaining stages.
- **Response data:**
  - Load, capability: `data_rdata_o = sram_rdata_i` (tag preserved).
  - Load, non-capability: `data_rdata_o = {1'b0, data[31:0]}`.
  - Error or store response: `data_rdata_o = 0`.
- **Response error:** `data_err_o` is 1 only on error responses.
- **Outstanding count:** `out_cnt` increments on accept and decrements on `data_rvalid_o`. Both in the same cycle leaves it unchanged. It never exceeds `MaxOutstanding`.
- **Back-to-back:** full throughput, one accept per cycle, whenever `MaxOutstanding >= ReadLatency`.
- **Mid-operation reset:** reset clears the pipeline and `out_cnt`. Requests in flight are dropped and produce no `data_rvalid_o` after reset is released.
- **Aborted requests:** a `req` deasserted without `gnt` has no effect.

## Timing
- **Reset values:** `data_gnt_o`, `data_rvalid_o`, `data_err_o`, `sram_cs_o`, `sram_we_o` = 0. `data_rdata_o`, `sram_addr_o`, `sram_wmask_o`, `sram_wdata_o` = 0. `out_cnt` = 0.
- **Combinational outputs:** `data_gnt_o` and all `sram_*` outputs are combinational from inputs and `out_cnt`. There is no path from `sram_rdata_i` to `data_gnt_o`.
- **Response cycle:** a request accepted in cycle t responds in cycle t+ReadLatency. `data_rvalid_o` is high for exactly one cycle.
- **No response backpressure:** the core always takes a response.
- **Ordering:** responses come out in accept order, including errors mixed with valid accesses.
- **Address wrap:** the subtraction is 32-bit modulo. Addresses below `AddrBase` wrap to large values and flag out of range.

## Test plan
- **Single load:** SRAM word 5 preloaded with 33'h1_DEAD_BEEF. Capability load at 0x200f_0014, ReadLatency=1, gives gnt in the request cycle and, one cycle later, rvalid=1, rdata=33'h1_DEAD_BEEF, err=0. The same load with is_cap=0 returns 33'h0_DEAD_BEEF.
- **Tag clear:** capability store of 33'h1_1234_5678 to 0x200f_0020, then a byte store be=4'b0001 wdata=0xAA to the same address. A following capability load returns 33'h0_1234_56AA.
- **Errors:**
  - Load at 0x2010_0000 gives rvalid with err=1, rdata=0 and no `sram_cs_o`.
  - Capability load at 0x200f_0002 gives err=1.
- **Backpressure and outstanding limit:** ReadLatency=3, MaxOutstanding=2, req held high. Grants occur in cycles 0 and 1, gnt is low in cycle 2, and gnt resumes in cycle 3 together with the first rvalid. `stall_i=1` holds gnt at 0.
- **Ordering:** interleaved good load, error, good store back-to-back (ReadLatency=2). Responses arrive in order with err pattern 0,1,0, on consecutive cycles.
- **Mid-operation reset:** `rst_i` pulsed for one cycle while two requests are outstanding. No rvalid appears afterwards, `out_cnt` is 0, and the next request is granted immediately.

Source files
------------

// File: rtl/cheri_data_sram_responder.sv
// Tagged-word data-port responder: grants core load/store requests, drives a single-port
// 33-bit SRAM, clears capability tags on ordinary stores and returns in-order responses.
module cheri_data_sram_responder #(
  parameter logic [31:0] AddrBase       = 32'h200f_0000,
  parameter logic [31:0] AddrSize       = 32'h0001_0000,
  parameter int unsigned SramAw         = 14,
  parameter int unsigned ReadLatency    = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              data_req_i,
  output logic              data_gnt_o,
  input  logic              data_we_i,
  input  logic              data_is_cap_i,
  input  logic [3:0]        data_be_i,
  input  logic [31:0]       data_addr_i,
  input  logic [32:0]       data_wdata_i,
  output logic              data_rvalid_o,
  output logic [32:0]       data_rdata_o,
  output logic              data_err_o,
  input  logic              stall_i,
  output logic              sram_cs_o,
  output logic              sram_we_o,
  output logic [SramAw-1:0] sram_addr_o,
  output logic [32:0]       sram_wmask_o,
  output logic [32:0]       sram_wdata_o,
  input  logic [32:0]       sram_rdata_i
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  typedef struct packed {
    logic vld;
    logic err;
    logic is_cap;
    logic we;
  } rsp_meta_t;

  rsp_meta_t [ReadLatency-1:0] meta_q, meta_d;
  logic [CntW-1:0]             out_cnt_q, out_cnt_d;

  logic [31:0] offset;
  logic        in_range, cap_bad, req_err;
  logic        rsp_now, has_room, accept, sram_wr;
  rsp_meta_t   rsp;
  logic [32:0] rsp_data;

  assign rsp     = meta_q[ReadLatency-1];
  assign rsp_now = rsp.vld;

  // Room check credits the response leaving this cycle; depends only on state.
  assign has_room = (out_cnt_q - CntW'(rsp_now)) < CntW'(MaxOutstanding);

  assign offset   = data_addr_i - AddrBase;
  assign in_range = offset < AddrSize;
  assign cap_bad  = data_is_cap_i & ((data_addr_i[1:0] != 2'b00) | (data_be_i != 4'hF));
  assign req_err  = ~in_range | cap_bad;

  assign data_gnt_o = data_req_i & ~stall_i & ~rst_i & has_room;
  assign accept     = data_gnt_o;

  assign sram_cs_o    = accept & ~req_err;
  assign sram_wr      = sram_cs_o & data_we_i;
  assign sram_we_o    = sram_wr;
  assign sram_addr_o  = sram_cs_o ? offset[SramAw+1:2] : '0;
  assign sram_wmask_o = sram_wr ? {1'b1, {8{data_be_i[3]}}, {8{data_be_i[2]}},
                                         {8{data_be_i[1]}}, {8{data_be_i[0]}}} : '0;
  // Ordinary stores always write the tag bit as zero, even for partial writes.
  assign sram_wdata_o = sram_wr ? {data_is_cap_i & data_wdata_i[32], data_wdata_i[31:0]} : '0;

  always_comb begin
    meta_d           = meta_q;
    meta_d[0].vld    = accept;
    meta_d[0].err    = req_err;
    meta_d[0].is_cap = data_is_cap_i;
    meta_d[0].we     = data_we_i;
    for (int i = 1; i < ReadLatency; i++) begin
      meta_d[i] = meta_q[i-1];
    end
  end

  always_comb begin
    out_cnt_d = out_cnt_q;
    if (accept && !rsp_now) begin
      out_cnt_d = out_cnt_q + CntW'(1);
    end else if (!accept && rsp_now) begin
      out_cnt_d = out_cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q    <= '0;
      out_cnt_q <= '0;
    end else begin
      meta_q    <= meta_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  // SRAM read data arrives one cycle after select, then rides along with its entry.
  if (ReadLatency == 1) begin : g_lat1
    assign rsp_data = sram_rdata_i;
  end else begin : g_latn
    logic [ReadLatency-1:1][32:0] data_q, data_d;

    always_comb begin
      data_d    = data_q;
      data_d[1] = sram_rdata_i;
      for (int i = 2; i < ReadLatency; i++) begin
        data_d[i] = data_q[i-1];
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        data_q <= '0;
      end else begin
        data_q <= data_d;
      end
    end

    assign rsp_data = data_q[ReadLatency-1];
  end

  assign data_rvalid_o = rsp.vld;
  assign data_err_o    = rsp.vld & rsp.err;
  assign data_rdata_o  = (rsp.vld & ~rsp.err & ~rsp.we)
                         ? (rsp.is_cap ? rsp_data : {1'b0, rsp_data[31:0]})
                         : '0;

endmodule

// File: tb/tb_cheri_data_sram_responder.sv
// Drives three responders (ReadLatency 1..3) with shared stimulus; each is checked every
// cycle against a queue-based reference model, plus directed literal expectations.
module tb_cheri_data_sram_responder;

  localparam logic [31:0] BASE = 32'h200f_0000;
  localparam logic [31:0] SIZE = 32'h0001_0000;
  localparam int          MAXO = 2;

  typedef struct {
    int          due;
    logic [32:0] d;
    logic        e;
  } pend_t;

  logic        clk = 1'b0;
  logic        rst, req, we, cap, stall;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [32:0] wd;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        gnt_a [3];
  logic        rv_a  [3];
  logic        err_a [3];
  logic        cs_a  [3];
  logic        swe_a [3];
  logic [13:0] sad_a [3];
  logic [32:0] rd_a  [3];
  logic [32:0] msk_a [3];
  logic [32:0] swd_a [3];

  task automatic chk(input string nm, input int inst, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cycle %0d got %h want %h", nm, inst, cyc, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input int inst, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cycle %0d got %b want %b", nm, inst, cyc, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int L = g + 1;
    logic [32:0] smem [64];
    logic [32:0] rmem [64];
    logic [32:0] srd;
    pend_t       pend [$];
    bit          inited = 1'b0;

    cheri_data_sram_responder #(
      .AddrBase(BASE), .AddrSize(SIZE), .SramAw(14), .ReadLatency(L), .MaxOutstanding(MAXO)
    ) u_dut (
      .clk_i(clk), .rst_i(rst),
      .data_req_i(req), .data_gnt_o(gnt_a[g]), .data_we_i(we), .data_is_cap_i(cap),
      .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wd),
      .data_rvalid_o(rv_a[g]), .data_rdata_o(rd_a[g]), .data_err_o(err_a[g]),
      .stall_i(stall),
      .sram_cs_o(cs_a[g]), .sram_we_o(swe_a[g]), .sram_addr_o(sad_a[g]),
      .sram_wmask_o(msk_a[g]), .sram_wdata_o(swd_a[g]), .sram_rdata_i(srd)
    );

    // Behavioural SRAM macro, aliased to 64 words.
    always @(posedge clk) begin
      if (cyc == 0) begin
        for (int i = 0; i < 64; i++) smem[i] <= '0;
        srd <= '0;
      end else if (cs_a[g]) begin
        if (swe_a[g])
          smem[sad_a[g][5:0]] <= (smem[sad_a[g][5:0]] & ~msk_a[g]) | (swd_a[g] & msk_a[g]);
        else
          srd <= smem[sad_a[g][5:0]];
      end
    end

    always @(negedge clk) begin : model
      logic [31:0] off;
      logic        e, xrv, xg, xcs;
      int          idx;
      logic [32:0] m, wv, ld;
      if (!inited) begin
        for (int i = 0; i < 64; i++) rmem[i] = '0;
        inited = 1'b1;
      end
      if (rst) begin
        chk1("rst_gnt", g, gnt_a[g], 1'b0);
        chk1("rst_rvalid", g, rv_a[g], 1'b0);
        chk1("rst_err", g, err_a[g], 1'b0);
        chk1("rst_cs", g, cs_a[g], 1'b0);
        chk1("rst_we", g, swe_a[g], 1'b0);
        chk("rst_rdata", g, rd_a[g], 33'h0);
        chk("rst_addr", g, 33'(sad_a[g]), 33'h0);
        chk("rst_wmask", g, msk_a[g], 33'h0);
        chk("rst_wdata", g, swd_a[g], 33'h0);
        pend.delete();
      end else begin
        off = addr - BASE;
        e   = !(off < SIZE) || (cap && (addr[1:0] != 2'b00 || be != 4'hF));
        xrv = (pend.size() > 0) && (pend[0].due == cyc);
        xg  = req && !stall && ((pend.size() - int'(xrv)) < MAXO);
        xcs = xg && !e;
        idx = int'(off[7:2]);
        m   = {1'b1, {8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        wv  = {cap & wd[32], wd[31:0]};
        chk1("gnt", g, gnt_a[g], xg);
        chk1("rvalid", g, rv_a[g], xrv);
        if (xrv) begin
          chk("rdata", g, rd_a[g], pend[0].d);
          chk1("err", g, err_a[g], pend[0].e);
          void'(pend.pop_front());
        end
        chk1("sram_cs", g, cs_a[g], xcs);
        if (xcs) begin
          chk1("sram_we", g, swe_a[g], we);
          chk("sram_addr", g, 33'(sad_a[g]), 33'(off[15:2]));
          if (we) begin
            chk("sram_wmask", g, msk_a[g], m);
            chk("sram_wdata", g, swd_a[g], wv);
          end
        end
        if (xg) begin
          ld = (e || we) ? 33'h0 : (cap ? rmem[idx] : {1'b0, rmem[idx][31:0]});
          pend.push_back('{cyc + L, ld, e});
          if (!e && we) rmem[idx] = (rmem[idx] & ~m) | (wv & m);
        end
      end
    end
  end

  task automatic drive(input logic r, input logic w, input logic c, input logic [3:0] b,
                       input logic [31:0] a, input logic [32:0] d, input logic s);
    req = r; we = w; cap = c; be = b; addr = a; wd = d; stall = s;
  endtask

  // One isolated request; every instance must grant it and respond after its own latency.
  task automatic op(input logic w, input logic c, input logic [3:0] b, input logic [31:0] a,
                    input logic [32:0] d, input logic [32:0] exp_rd, input logic exp_err);
    @(posedge clk); #1;
    drive(1'b1, w, c, b, a, d, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk1("op_gnt", i, gnt_a[i], 1'b1);
      chk1("op_cs", i, cs_a[i], !exp_err);
    end
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      req = 1'b0;
      @(negedge clk);
      chk1("op_rvalid", k - 1, rv_a[k-1], 1'b1);
      chk("op_rdata", k - 1, rd_a[k-1], exp_rd);
      chk1("op_err", k - 1, err_a[k-1], exp_err);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [4:0] gnt_pat;
    logic [4:0] rv_pat;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 33'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    op(1'b1, 1'b1, 4'hF, 32'h200f_0014, 33'h1_DEAD_BEEF, 33'h0, 1'b0);
    op(1'b0, 1'b1, 4'hF, 32'h200f_0014, 33'h0, 33'h1_DEAD_BEEF, 1'b0);
    op(1'b0, 1'b0, 4'hF, 32'h200f_0014, 33'h0, 33'h0_DEAD_BEEF, 1'b0);
    op(1'b1, 1'b1, 4'hF, 32'h200f_0020, 33'h1_1234_5678, 33'h0, 1'b0);
    op(1'b1, 1'b0, 4'b0001, 32'h200f_0020, 33'h0_0000_00AA, 33'h0, 1'b0);
    op(1'b0, 1'b1, 4'hF, 32'h200f_0020, 33'h0, 33'h0_1234_56AA, 1'b0);
    op(1'b0, 1'b0, 4'hF, 32'h2010_0000, 33'h0, 33'h0, 1'b1);
    op(1'b0, 1'b1, 4'hF, 32'h200f_0002, 33'h0, 33'h0, 1'b1);
    op(1'b0, 1'b0, 4'hF, 32'h200e_fffc, 33'h0, 33'h0, 1'b1);

    // Outstanding limit on the latency-3 instance, then a stall cycle.
    gnt_pat = 5'b01011;
    rv_pat  = 5'b11000;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 1'b0, 4'hF, 32'h200f_0014, 33'h0, k == 4);
      @(negedge clk);
      chk1("bp_gnt", 2, gnt_a[2], gnt_pat[k]);
      chk1("bp_rvalid", 2, rv_a[2], rv_pat[k]);
      if (k == 4) begin
        chk1("stall_gnt", 0, gnt_a[0], 1'b0);
        chk1("stall_gnt", 1, gnt_a[1], 1'b0);
      end
    end
    @(posedge clk); #1 req = 1'b0;
    repeat (5) @(posedge clk);

    // Good load, error, good store back-to-back on the latency-2 instance.
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      case (k)
        0: drive(1'b1, 1'b0, 1'b0, 4'hF, 32'h200f_0014, 33'h0, 1'b0);
        1: drive(1'b1, 1'b0, 1'b0, 4'hF, 32'h2010_0000, 33'h0, 1'b0);
        2: drive(1'b1, 1'b1, 1'b0, 4'hF, 32'h200f_0040, 33'h1_0BAD_F00D, 1'b0);
        default: req = 1'b0;
      endcase
      @(negedge clk);
      if (k < 3) chk1("ord_gnt", 1, gnt_a[1], 1'b1);
      if (k >= 2) begin
        chk1("ord_rvalid", 1, rv_a[1], 1'b1);
        chk1("ord_err", 1, err_a[1], k == 3);
      end
      if (k == 2) chk("ord_rdata", 1, rd_a[1], 33'h0_DEAD_BEEF);
    end
    repeat (5) @(posedge clk);

    // Reset pulse with two requests in flight.
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      rst = (k == 2);
      if (k < 2 || k == 7) drive(1'b1, 1'b0, 1'b1, 4'hF, 32'h200f_0020, 33'h0, 1'b0);
      else req = 1'b0;
      @(negedge clk);
      if (k >= 3 && k <= 6)
        for (int i = 0; i < 3; i++) chk1("rst_drop_rvalid", i, rv_a[i], 1'b0);
      if (k == 7)
        for (int i = 0; i < 3; i++) chk1("post_rst_gnt", i, gnt_a[i], 1'b1);
    end
    @(posedge clk); #1 req = 1'b0;
    repeat (5) @(posedge clk);

    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      rst   = ($urandom_range(0, 399) == 0);
      req   = ($urandom_range(0, 9) < 7);
      stall = ($urandom_range(0, 9) < 2);
      we    = 1'($urandom);
      cap   = 1'($urandom);
      be    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      case ($urandom_range(0, 9))
        0: addr = $urandom;
        1: addr = BASE - 32'($urandom_range(1, 16));
        2: addr = BASE + SIZE + 32'($urandom_range(0, 16));
        default: begin
          addr = BASE + 32'($urandom_range(0, 255));
          if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
        end
      endcase
      wd = {1'($urandom), 32'($urandom)};
    end
    @(posedge clk); #1;
    rst = 1'b0;
    req = 1'b0;
    repeat (6) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
